// File: rtl/edf_sched_pkg.sv
`default_nettype none
// ==========================================================================
// edf_sched_pkg -- shared types and the modular deadline compare for EDF
// Rev 1.0
// ==========================================================================
package edf_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // eop flag sits this many bits below the MSB of a queue word
  localparam int EOP_FROM_MSB = 0;

  // a is earlier than b when (a - b) taken in w bits is negative
  function automatic logic dl_earlier(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] diff;
    diff = a - b;
    return diff[w-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/edf_min_sel.sv
`default_nettype none
// ==========================================================================
// edf_min_sel -- combinational earliest-deadline search, rr tie-break
// Rev 1.0
// ==========================================================================
module edf_min_sel
  import edf_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int DL_W  = 12,
  parameter int QID_W = 2
) (
  input  logic [N-1:0]      empty,
  input  logic [N*DL_W-1:0] head_dl,
  input  logic [QID_W-1:0]  rr_ptr,
  output logic [QID_W-1:0]  winner,
  output logic              any_valid
);

  logic             vld [N];
  logic [DL_W-1:0]  dlv [N];
  logic [QID_W-1:0] idx [N];

  // Leaf p holds queue rr_ptr+p, so a lower slot always means "sooner after
  // rr_ptr"; each tree node keeps its left child unless the right one is
  // strictly earlier, which gives the round-robin tie-break for free.
  always_comb begin
    for (int p = 0; p < N; p++) begin
      idx[p] = rr_ptr + QID_W'(p);
      vld[p] = ~empty[idx[p]];
      dlv[p] = head_dl[int'(idx[p])*DL_W +: DL_W];
    end
    for (int s = 1; s < N; s = s * 2) begin
      for (int p = 0; p < N; p = p + 2 * s) begin
        if (vld[p+s] && (!vld[p] || dl_earlier(32'(dlv[p+s]), 32'(dlv[p]), DL_W))) begin
          vld[p] = 1'b1;
          dlv[p] = dlv[p+s];
          idx[p] = idx[p+s];
        end
      end
    end
    winner    = idx[0];
    any_valid = vld[0];
  end

endmodule
`default_nettype wire

// File: rtl/edf_out_scheduler.sv
`default_nettype none
// ==========================================================================
// edf_out_scheduler -- EDF egress scheduler with 2-entry skid output buffer
// Rev 1.0
// ==========================================================================
module edf_out_scheduler
  import edf_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DL_W       = 12,
  parameter int QID_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            q_empty,
  input  logic [N*DL_W-1:0]       q_head_dl,
  input  logic [N*DATA_WIDTH-1:0] q_head_data,
  output logic [N-1:0]            q_rd_en,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [QID_W-1:0]        out_qid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int EOP_BIT = DATA_WIDTH - 1 - EOP_FROM_MSB;

  state_t                state, state_nxt;
  logic [QID_W-1:0]      sel, rr_ptr, winner;
  logic                  any_valid;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [QID_W-1:0]      buf_qid  [2];
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  pop, drain, slot_free, head_eop;

  edf_min_sel #(
    .N     (N),
    .DL_W  (DL_W),
    .QID_W (QID_W)
  ) u_min_sel (
    .empty     (q_empty),
    .head_dl   (q_head_dl),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign head_word = q_head_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign head_eop  = head_word[EOP_BIT];
  assign out_valid = (count != 2'd0);
  assign drain     = out_valid & out_ready;
  assign slot_free = (count < 2'd2) | drain;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (any_valid) state_nxt = XFER;
      XFER: begin
        pop = ~q_empty[sel] & slot_free;
        if (pop && head_eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign q_rd_en  = pop ? (N'(1) << sel) : '0;
  assign busy     = (state == XFER);
  assign out_data = buf_data[0];
  assign out_qid  = buf_qid[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && any_valid) sel <= winner;
      if (pop && head_eop)            rr_ptr <= sel + 1'b1;
    end
  end

  // Entry 0 is the head; a drain shifts entry 1 down and a push lands in the
  // first slot left free after that shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_qid[0]  <= '0;
      buf_qid[1]  <= '0;
    end else begin
      count <= count + {1'b0, pop} - {1'b0, drain};
      if (drain) begin
        buf_data[0] <= buf_data[1];
        buf_qid[0]  <= buf_qid[1];
      end
      if (pop) begin
        if (count == 2'd0 || (count == 2'd1 && drain)) begin
          buf_data[0] <= head_word;
          buf_qid[0]  <= sel;
        end else begin
          buf_data[1] <= head_word;
          buf_qid[1]  <= sel;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edf_out_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_edf_out_scheduler -- scoreboard bench with behavioural EDF queue model
// Rev 1.0
// ==========================================================================
module tb_edf_out_scheduler;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int DLW = 12;
  localparam int QW  = 2;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [DLW-1:0] dl;
    logic [7:0]     pos;
  } word_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [QW-1:0] qid;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      q_empty;
  logic [N*DLW-1:0]  q_head_dl;
  logic [N*DW-1:0]   q_head_data;
  logic [N-1:0]      q_rd_en;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [QW-1:0]     out_qid;
  logic              out_ready;
  logic              busy;

  edf_out_scheduler #(
    .N          (N),
    .DATA_WIDTH (DW),
    .DL_W       (DLW),
    .QID_W      (QW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_empty     (q_empty),
    .q_head_dl   (q_head_dl),
    .q_head_data (q_head_data),
    .q_rd_en     (q_rd_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_qid     (out_qid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  word_t    tq [N][$];
  exp_t     exp_q[$];
  int       checks = 0, errors = 0;
  int       m_rr = 0;
  int       ready_mode = 0, stall_mode = 0;
  int       cyc = 0, hide_cnt = 0, pops_seen = 0, occ = 0;
  logic [N-1:0] pend = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic bit earlier(input int a, input int b);
    return ((a - b) & ((1 << DLW) - 1)) >= (1 << (DLW - 1));
  endfunction

  task automatic add_pkt(input int q, input int len, input int dl);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.data = {(k == len - 1) ? 1'b1 : 1'b0, 15'($urandom)};
      w.dl   = DLW'(dl);
      w.pos  = 8'(k);
      tq[q].push_back(w);
    end
  endtask

  // Reference: serve whole packets, earliest head deadline first, ties to the
  // first queue at or after the round-robin pointer.
  task automatic build_expected();
    word_t cp [N][$];
    word_t w;
    int best;
    for (int i = 0; i < N; i++) cp[i] = tq[i];
    while (1) begin
      best = -1;
      for (int k = 0; k < N; k++) begin
        int q;
        q = (m_rr + k) % N;
        if (cp[q].size() > 0)
          if (best < 0 || earlier(int'(cp[q][0].dl), int'(cp[best][0].dl))) best = q;
      end
      if (best < 0) break;
      do begin
        w = cp[best].pop_front();
        exp_q.push_back({w.data, QW'(best)});
      end while (!w.data[DW-1]);
      m_rr = (best + 1) % N;
    end
  endtask

  task automatic sync_load();
    @(posedge clk);
    #3;
  endtask

  task automatic start(input int rmode, input int smode);
    ready_mode = rmode;
    stall_mode = smode;
    build_expected();
    cyc       = 0;
    hide_cnt  = 0;
    pops_seen = 0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (tq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && !out_valid && all_empty()) && n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s: timeout, %0d words still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Driver: presents the modelled FWFT queues and records DUT pops.
  initial begin
    bit vis;
    bit drn;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++)
        if (pend[i] && tq[i].size() > 0) void'(tq[i].pop_front());
      pend = '0;
      for (int i = 0; i < N; i++) begin
        vis = (tq[i].size() > 0);
        if (vis && stall_mode == 1 && tq[i][0].pos != 0 && ($urandom % 3) == 0) vis = 1'b0;
        if (vis && stall_mode == 2 && tq[i][0].pos == 2 && hide_cnt < 3) begin
          vis = 1'b0;
          hide_cnt++;
        end
        q_empty[i] = ~vis;
        if (tq[i].size() > 0) begin
          q_head_dl[i*DLW +: DLW] = tq[i][0].dl;
          q_head_data[i*DW +: DW] = tq[i][0].data;
        end else begin
          q_head_dl[i*DLW +: DLW] = '0;
          q_head_data[i*DW +: DW] = '0;
        end
      end
      case (ready_mode)
        1:       out_ready = (($urandom % 10) < 7);
        2:       out_ready = !(cyc >= 2 && cyc <= 5);
        default: out_ready = 1'b1;
      endcase
      #1;
      if (rst_n) begin
        drn = out_valid && out_ready;
        if (q_rd_en != '0) begin
          checks++;
          if ($countones(q_rd_en) != 1 || (q_rd_en & q_empty) != '0) begin
            errors++;
            $display("FAIL pop_legal: q_rd_en %b with q_empty %b", q_rd_en, q_empty);
          end else begin
            pend = q_rd_en;
          end
          pops_seen++;
          occ = occ + 1 - (drn ? 1 : 0);
          checks++;
          if (occ > 2) begin
            errors++;
            $display("FAIL buffer_depth: occupancy %0d exceeds 2", occ);
          end
        end else if (drn) begin
          occ--;
        end
      end
    end
  end

  // Monitor: compares every accepted output word against the scoreboard.
  initial begin
    bit            held = 1'b0;
    logic [DW-1:0] h_data;
    logic [QW-1:0] h_qid;
    exp_t          e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held && out_valid) begin
          checks++;
          if (out_data !== h_data || out_qid !== h_qid) begin
            errors++;
            $display("FAIL stall_hold: got %h/q%0d held %h/q%0d", out_data, out_qid, h_data, h_qid);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_word: unexpected word %h from q%0d", out_data, out_qid);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_qid !== e.qid) begin
              errors++;
              $display("FAIL out_word: got %h/q%0d expected %h/q%0d", out_data, out_qid, e.data, e.qid);
            end
          end
        end
        held   = out_valid && !out_ready;
        h_data = out_data;
        h_qid  = out_qid;
      end
    end
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    q_empty     = '1;
    q_head_dl   = '0;
    q_head_data = '0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_rd_en", 32'(q_rd_en), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_qid",   32'(out_qid), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // single queue, cycle-exact timing
    sync_load();
    add_pkt(0, 3, 100);
    start(0, 0);
    @(negedge clk); #3;
    chk("arb_no_pop", 32'(q_rd_en), 0);
    chk("arb_busy",   32'(busy), 0);
    @(negedge clk); #3;
    chk("pop1_rd_en", 32'(q_rd_en), 1);
    chk("pop1_busy",  32'(busy), 1);
    @(negedge clk); #3;
    chk("pop2_rd_en", 32'(q_rd_en), 1);
    chk("pop2_valid", 32'(out_valid), 1);
    @(negedge clk); #3;
    chk("pop3_rd_en", 32'(q_rd_en), 1);
    @(negedge clk); #3;
    chk("done_rd_en", 32'(q_rd_en), 0);
    chk("done_busy",  32'(busy), 0);
    chk("done_valid", 32'(out_valid), 1);
    wait_idle("single");

    sync_load(); add_pkt(0, 1, 7); add_pkt(1, 1, 7); start(0, 0); wait_idle("tie_rr1");
    sync_load(); add_pkt(1, 1, 50); add_pkt(2, 1, 20); add_pkt(3, 1, 80); start(0, 0); wait_idle("edf_order");
    sync_load(); add_pkt(0, 1, 4090); add_pkt(1, 1, 5); start(0, 0); wait_idle("wrap");
    sync_load(); add_pkt(3, 4, 200); start(2, 0); wait_idle("backpressure");
    sync_load(); add_pkt(2, 4, 4000); add_pkt(0, 1, 0); start(0, 2); wait_idle("underflow");

    for (int r = 0; r < 25; r++) begin
      int base;
      sync_load();
      base = int'($urandom % 4096);
      for (int q = 0; q < N; q++) begin
        int np;
        np = int'($urandom % 3);
        for (int k = 0; k < np; k++)
          add_pkt(q, 1 + int'($urandom % 4), (base + 100 * int'($urandom % 8)) % 4096);
      end
      start(1, 1);
      wait_idle("random");
    end

    sync_load(); add_pkt(1, 1, 10); start(0, 0); wait_idle("pre_reset");

    // asynchronous reset in the middle of a packet
    sync_load(); add_pkt(2, 4, 300); start(0, 0);
    n = 0;
    while (pops_seen < 2 && n < 50) begin
      @(negedge clk); #3;
      n++;
    end
    chk("reset_reach_word2", 32'(pops_seen >= 2), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data",  32'(out_data), 0);
    chk("mid_rst_qid",   32'(out_qid), 0);
    chk("mid_rst_rd_en", 32'(q_rd_en), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    for (int i = 0; i < N; i++) tq[i].delete();
    exp_q.delete();
    pend = '0;
    occ  = 0;
    m_rr = 0;
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;

    sync_load(); add_pkt(1, 1, 500); add_pkt(3, 1, 500); start(0, 0); wait_idle("post_reset_tie");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
